// File: rtl/fsm_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial stage.
// The counter width is derived from the word width by cnt_w().
package fsm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A 1-bit counter is kept even in degenerate cases so the port widths stay legal.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W = cnt_w(8);

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in, serial-out stage: one word in flight plus one held word,
// emitting one bit per clock with no gap between back-to-back words.
//
// state | meaning
// IDLE  | line parked at IDLE_LEVEL, waiting for a word
// SHIFT | sreg bits going out, cnt = index of the bit on the line
module piso_bit_serializer
    import fsm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
    logic [WIDTH-1:0] r_hold, w_hold_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_hold_full, w_hold_full_nxt;

    logic             w_transfer;
    logic             w_last;
    logic [WIDTH-1:0] w_shifted;

    assign w_transfer = data_valid & ~r_hold_full;
    assign w_last     = (r_cnt == LAST);
    assign w_shifted  = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_hold      <= w_hold_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_hold_nxt      = r_hold;
        w_cnt_nxt       = r_cnt;
        w_hold_full_nxt = r_hold_full;

        case (r_state)
            IDLE: begin
                if (w_transfer) begin
                    w_sreg_nxt  = data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_sreg_nxt = w_shifted;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (w_transfer) begin
                        w_hold_nxt      = data_in;
                        w_hold_full_nxt = 1'b1;
                    end
                end else if (r_hold_full) begin
                    w_sreg_nxt      = r_hold;
                    w_hold_full_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                end else if (w_transfer) begin
                    // Bypass: a word arriving on the last-bit edge skips the holding register.
                    w_sreg_nxt = data_in;
                    w_cnt_nxt  = '0;
                end else begin
                    w_sreg_nxt  = w_shifted;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign data_ready  = ~r_hold_full;
    assign bit_valid   = (r_state == SHIFT);
    assign bit_out     = (r_state == SHIFT) ? (MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0]) : IDLE_LEVEL;
    assign frame_start = (r_state == SHIFT) && (r_cnt == '0);
    assign busy        = (r_state == SHIFT) | r_hold_full;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: MSB-first and LSB-first instances share stimulus;
// a queue-of-pending-bits model is compared every cycle, plus literal bit checks.
module tb_piso_bit_serializer;

    localparam int W = 8;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] data_in;
    logic         data_valid;

    logic m_ready, m_bit, m_bv, m_fs, m_busy;
    logic l_ready, l_bit, l_bv, l_fs, l_busy;

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(m_ready), .bit_out(m_bit), .bit_valid(m_bv), .frame_start(m_fs), .busy(m_busy)
    );

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(l_ready), .bit_out(l_bit), .bit_valid(l_bv), .frame_start(l_fs), .busy(l_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every bit not yet on the line, front = bit currently driven.
    logic mq[$];
    logic lq[$];
    logic tr_model;

    function automatic logic model_ready();
        return (mq.size() <= W);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            lq.delete();
        end else begin
            tr_model = data_valid && model_ready();
            if (mq.size() > 0) begin
                void'(mq.pop_front());
                void'(lq.pop_front());
            end
            if (tr_model) begin
                for (int i = 0; i < W; i++) begin
                    mq.push_back(data_in[W-1-i]);
                    lq.push_back(data_in[i]);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            int n;
            logic e_bv, e_fs, e_rdy, e_mb, e_lb;
            n     = mq.size();
            e_bv  = (n > 0);
            e_fs  = (n > 0) && (n % W == 0);
            e_rdy = (n <= W);
            e_mb  = (n > 0) ? mq[0] : 1'b1;
            e_lb  = (n > 0) ? lq[0] : 1'b1;
            chk("msb_bit_out",     m_bit,   e_mb);
            chk("msb_bit_valid",   m_bv,    e_bv);
            chk("msb_frame_start", m_fs,    e_fs);
            chk("msb_busy",        m_busy,  e_bv);
            chk("msb_data_ready",  m_ready, e_rdy);
            chk("lsb_bit_out",     l_bit,   e_lb);
            chk("lsb_bit_valid",   l_bv,    e_bv);
            chk("lsb_frame_start", l_fs,    e_fs);
            chk("lsb_busy",        l_busy,  e_bv);
            chk("lsb_data_ready",  l_ready, e_rdy);
        end
    end

    // Overlapping 0110 detector on the MSB-first stream.
    logic       det_en = 1'b0;
    logic [3:0] det_win;
    int         det_nb;
    int         det_cnt;

    always @(negedge clock) begin
        if (det_en && reset_n && m_bv) begin
            det_win = {det_win[2:0], m_bit};
            det_nb++;
            if (det_nb >= 4 && det_win == 4'b0110) det_cnt++;
        end
    end

    // Present a word and return just after the edge that accepts it.
    task automatic send(input logic [W-1:0] w, input bit keep);
        bit ok;
        ok         = 1'b0;
        data_in    = w;
        data_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            if (model_ready()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        if (!keep) data_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clock);
        #1;
    endtask

    logic [7:0] exp_a5;
    logic [7:0] exp_lsb01;

    initial begin
        reset_n    = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        #3;
        chk("t1_ready",  m_ready, 1'b1);
        chk("t1_bitout", m_bit,   1'b1);
        chk("t1_bvalid", m_bv,    1'b0);
        chk("t1_busy",   m_busy,  1'b0);
        chk("t1_fstart", m_fs,    1'b0);
        #9 reset_n = 1'b1;
        idle_cycles(2);

        // Single 0xA5, MSB first: 1,0,1,0,0,1,0,1
        exp_a5 = 8'b1010_0101;
        send(8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("t2_bit",    m_bit, exp_a5[7-i]);
            chk("t2_fstart", m_fs,  (i == 0));
        end
        @(negedge clock);
        chk("t2_idle_bv",  m_bv,  1'b0);
        chk("t2_idle_bit", m_bit, 1'b1);
        idle_cycles(2);

        // Back-to-back 0x36, 0x6C with valid held high
        det_win = 4'b0;
        det_nb  = 0;
        det_cnt = 0;
        det_en  = 1'b1;
        send(8'h36, 1'b1);
        send(8'h6C, 1'b0);
        @(negedge clock);
        chk("t3_ready_held", m_ready, 1'b0);
        idle_cycles(17);
        det_en = 1'b0;
        chk("t3_det_0110", det_cnt, 4);
        chk("t3_idle_bv",  m_bv,    1'b0);

        // LSB first, 0x01 -> 1,0,0,0,0,0,0,0
        exp_lsb01 = 8'b1000_0000;
        send(8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("t4_lsb_bit", l_bit, exp_lsb01[7-i]);
        end
        @(negedge clock);
        chk("t4_idle_bit", l_bit, 1'b1);
        idle_cycles(2);

        // Bypass: second word offered only during the last bit of the first
        send(8'hC3, 1'b0);
        idle_cycles(7);
        chk("t5_hold_empty", m_ready, 1'b1);
        send(8'h5A, 1'b0);
        @(negedge clock);
        chk("t5_fstart", m_fs,  1'b1);
        chk("t5_bv",     m_bv,  1'b1);
        chk("t5_bit",    m_bit, 1'b0);
        idle_cycles(10);

        // Reset mid-word with a held word
        send(8'hFF, 1'b1);
        send(8'h0F, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_bv",    m_bv,    1'b0);
        chk("t6_busy",  m_busy,  1'b0);
        chk("t6_ready", m_ready, 1'b1);
        chk("t6_bit",   m_bit,   1'b1);
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(1);
        send(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("t6_new_bit",    m_bit, 1'b0);
            chk("t6_new_fstart", m_fs,  (i == 0));
        end
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in, serial-out stage directly upstream of the Mealy sequence detectors in FSM/. Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on bit_out, which feeds a detector's input bit. A one-word holding register gives gap-free back-to-back words. The line idles at IDLE_LEVEL so a downstream detector sees no false patterns between words.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
IDLE_LEVEL, 1, value driven on bit_out while no word is being shifted.

Ports:
clock  input  1  single clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  parallel word, sampled on handshake.
data_valid  input  1  source has a word on data_in.
data_ready  output  1  block can accept a word this cycle.
bit_out  output  1  serial bit to the detector.
bit_valid  output  1  bit_out carries a data bit.
frame_start  output  1  high during the first bit of each word.
busy  output  1  SHIFT state or holding register occupied.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, shift reg=0, cnt=0, hold_full=0.
- Reset outputs: data_ready=1, bit_out=IDLE_LEVEL, bit_valid=0, frame_start=0, busy=0.
- Transfer occurs on a rising edge with data_valid=1 and data_ready=1.
- data_ready = !hold_full, decoded from registers only; no comb path from data_valid.
- Outputs are decoded from registers only; no input-to-output comb paths.
- State registers: state {IDLE, SHIFT}; sreg[WIDTH]; cnt[clog2(WIDTH)]; hold[WIDTH]; hold_full.
- IDLE:
  - bit_out=IDLE_LEVEL, bit_valid=0.
  - On transfer: sreg<=data_in, cnt<=0, state<=SHIFT.
- SHIFT:
  - bit_valid=1.
  - bit_out = sreg[WIDTH-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0).
  - frame_start = (cnt==0).
  - Each edge: shift sreg toward the output end, cnt<=cnt+1.
  - cnt<WIDTH-1 and transfer: hold<=data_in, hold_full<=1.
- Last bit, cnt==WIDTH-1, priority order:
  - (a) hold_full: sreg<=hold, hold_full<=0, cnt<=0, stay in SHIFT.
  - (b) else transfer this edge: sreg<=data_in, cnt<=0, stay in SHIFT. This is the bypass case.
  - (c) else: state<=IDLE.
- Latency: word accepted at edge k; first bit on bit_out in cycle k+1; last bit in cycle k+WIDTH.
- Throughput: one bit per clock with no idle gap while the source keeps data_valid high.
- Simultaneous load and hold: impossible, because data_ready=0 whenever hold_full=1.
- cnt wraps only via the explicit reload to 0; it never counts past WIDTH-1.
- Reset mid-word: the in-flight word and the held word are discarded; bit_out returns to IDLE_LEVEL immediately (async).
- busy = (state==SHIFT) | hold_full.

Decomposition:
- Package fsm_pkg: state enum {IDLE, SHIFT} and the constant CNT_W = $clog2(WIDTH), with a function form for the parameterised case.
- Single flat module.
- The holding register is too small to justify a sub-module; no sub-module.

Test Plan:
1. Assert reset_n=0 mid-cycle -> outputs immediately: data_ready=1, bit_out=1, bit_valid=0, busy=0.
2. WIDTH=8, MSB_FIRST=1: one word 0xA5 accepted at edge k -> cycles k+1..k+8 give bits 1,0,1,0,0,1,0,1, frame_start only at k+1. Cycle k+9: bit_valid=0, bit_out=1.
3. Back-to-back 0x36 then 0x6C with data_valid held high:
   - 16 contiguous valid bits 00110110 01101100.
   - data_ready=0 from the edge 0x6C enters hold until its reload.
   - Downstream seq_detect_0110 pulses on 0110 matches.
4. MSB_FIRST=0, word 0x01 -> bits 1,0,0,0,0,0,0,0, then idle.
5. Second word presented exactly at the last-bit edge of the first, with hold empty -> bypass load, no gap, frame_start on the next cycle.
6. reset_n pulsed low after 3 bits of 0xFF with a word held -> bit_valid=0 and busy=0 at once. After release, the next accepted word shifts from cnt=0 and the old data never appears.
